hazard_pipe_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. Drives the IF/ID register's stall_i/flush_i, the PC write enable, the ID/EX bubble and a global freeze.
- Resolves load-use hazards, taken-branch flushes, multi-cycle EX operations and data-memory wait states.
- Guarantees that the IF/ID register never sees stall and flush in the same cycle.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_lat_cnt.sv | 33 +++
 rtl/hazard_pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_pipe_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: FSM state encoding and widths.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EX_BUSY  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W      = 4;
    localparam int STAT_W     = 32;

endpackage

// File: rtl/hazard_lat_cnt.sv
// Loadable down-counter timing the EX stage of a multi-cycle op.
// zero_o flags that the count after this cycle's load/decrement is zero.
module hazard_lat_cnt
    import hazard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (load-use, branch, multi-cycle EX, mem wait).
// Optional HAZARD_STAT_EN adds saturating stall/flush cycle counters.
//
// state       | meaning
// ST_RUN      | pipeline flowing; load-use / branch / freeze sources resolved here
// ST_EX_BUSY  | multi-cycle EX op counting down, whole pipe frozen
// ST_MEM_WAIT | data memory access pending, frozen until mem_ack_i
module hazard_pipe_ctrl
    import hazard_pkg::*;
#(
    parameter int MULTI_LAT = 4,
    parameter int REG_AW    = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_branch_taken_i,
    input  logic              ex_multi_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              pc_write_o,
    output logic              if_id_stall_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              freeze_o,
`ifdef HAZARD_STAT_EN
    output logic [STAT_W-1:0] stall_cnt_o,
    output logic [STAT_W-1:0] flush_cnt_o,
`endif
    output logic [1:0]        state_o
);

    localparam bit               MULTI_EN = (MULTI_LAT > 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = (MULTI_LAT > 2) ? CNT_W'(MULTI_LAT - 2) : '0;

    state_t state_q;
    logic   ex_done_q;
    logic   mem_pend, lu, mstart, freeze, lat_zero;

    assign mem_pend = mem_req_i & ~mem_ack_i;
    assign lu       = ex_memread_i & (ex_rd_i != '0) &
                      ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
    assign mstart   = ex_multi_i & ~ex_done_q & MULTI_EN;

    // The ack cycle of MEM_WAIT is already unfrozen so the pipe advances with the data.
    assign freeze = (state_q == ST_EX_BUSY) |
                    ((state_q == ST_MEM_WAIT) & ~mem_ack_i) |
                    ((state_q == ST_RUN) & (mem_pend | mstart));

    hazard_lat_cnt u_lat_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     ((state_q == ST_RUN) & mstart),
        .load_val_i (LAT_LOAD),
        .dec_i      (state_q == ST_EX_BUSY),
        .zero_o     (lat_zero)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_RUN;
            ex_done_q <= 1'b0;
        end else begin
            ex_done_q <= 1'b0;
            unique case (state_q)
                ST_RUN: begin
                    if (mstart) begin
                        if (!lat_zero)
                            state_q <= ST_EX_BUSY;
                        else if (mem_pend)
                            state_q <= ST_MEM_WAIT;
                        else
                            ex_done_q <= 1'b1;
                    end else if (mem_pend) begin
                        state_q <= ST_MEM_WAIT;
                    end
                end
                ST_EX_BUSY: begin
                    if (lat_zero) begin
                        if (mem_pend) begin
                            state_q <= ST_MEM_WAIT;
                        end else begin
                            state_q   <= ST_RUN;
                            ex_done_q <= 1'b1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack_i)
                        state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        pc_write_o    = 1'b0;
        if_id_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        freeze_o      = 1'b0;
        if (rst_i) begin
            freeze_o = freeze;
            if (freeze) begin
                if_id_stall_o = 1'b1;
            end else if (lu) begin
                if_id_stall_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (id_branch_taken_i) begin
                if_id_flush_o = 1'b1;
                pc_write_o    = 1'b1;
            end else begin
                pc_write_o = 1'b1;
            end
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_STAT_EN
    logic [STAT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (if_id_stall_o && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + STAT_W'(1);
            if (if_id_flush_o && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + STAT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Scoreboard bench for hazard_pipe_ctrl (MULTI_LAT=4): directed vectors plus a random invariant run.
module tb_hazard_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic       ex_memread_i = 1'b0, id_branch_taken_i = 1'b0, ex_multi_i = 1'b0;
    logic       mem_req_i = 1'b0, mem_ack_i = 1'b0;
    logic       pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, freeze_o;
    logic [1:0] state_o;
`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    hazard_pipe_ctrl #(.MULTI_LAT(4), .REG_AW(5)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .id_rs1_i          (id_rs1_i),
        .id_rs2_i          (id_rs2_i),
        .ex_memread_i      (ex_memread_i),
        .ex_rd_i           (ex_rd_i),
        .id_branch_taken_i (id_branch_taken_i),
        .ex_multi_i        (ex_multi_i),
        .mem_req_i         (mem_req_i),
        .mem_ack_i         (mem_ack_i),
        .pc_write_o        (pc_write_o),
        .if_id_stall_o     (if_id_stall_o),
        .if_id_flush_o     (if_id_flush_o),
        .id_ex_flush_o     (id_ex_flush_o),
        .freeze_o          (freeze_o),
`ifdef HAZARD_STAT_EN
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o),
`endif
        .state_o           (state_o)
    );

    always #5 clk = ~clk;

    // Expected vector: {pc_write, if_id_stall, if_id_flush, id_ex_flush, freeze, state[1:0]}
    localparam logic [6:0] E_RST  = 7'b0000000;
    localparam logic [6:0] E_NORM = 7'b1000000;
    localparam logic [6:0] E_LU   = 7'b0101000;
    localparam logic [6:0] E_BR   = 7'b1010000;
    localparam logic [6:0] E_FR0  = 7'b0100100;
    localparam logic [6:0] E_FR1  = 7'b0100101;
    localparam logic [6:0] E_FR2  = 7'b0100110;
    localparam logic [6:0] E_ACK  = 7'b1000010;

    typedef struct {
        logic [6:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic cyc(input logic rst, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                       input logic mu, input logic rq, input logic ak,
                       input logic [6:0] exp, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_i = rst; ex_memread_i = mr; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
        id_branch_taken_i = br; ex_multi_i = mu; mem_req_i = rq; mem_ack_i = ak;
        e.exp = exp;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [6:0] exp, input string nm);
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp, nm);
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [6:0] act;
        act = {pc_write_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, freeze_o, state_o};
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got %b want %b", e.name, act, e.exp);
            end
        end
        if (rst_i) begin
            checks++;
            if ((if_id_stall_o & if_id_flush_o) !== 1'b0) begin
                failures++;
                $display("FAIL stall_and_flush: got stall=%b flush=%b want not both 1",
                         if_id_stall_o, if_id_flush_o);
            end
            checks++;
            if (pc_write_o !== ~if_id_stall_o) begin
                failures++;
                $display("FAIL pc_vs_stall: got pc_write=%b stall=%b want pc_write=!stall",
                         pc_write_o, if_id_stall_o);
            end
        end
    end

    initial begin
        // reset held: outputs all zero even with a branch present
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_RST, "reset_hold0");
        cyc(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, "reset_hold1");
        idle(E_NORM, "post_reset");

        // load-use
        cyc(1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, E_LU, "lu_rs2");
        idle(E_NORM, "lu_one_cycle");
        cyc(1'b1, 1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, E_LU, "lu_rs1");
        cyc(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM, "lu_rd0");
        cyc(1'b1, 1'b1, 5'd6, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, E_NORM, "lu_nomatch");

        // branch
        cyc(1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_BR, "branch");
        cyc(1'b1, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, E_LU, "branch_lu");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, E_BR, "branch_retry");

        // multi-cycle op, MULTI_LAT=4: freeze cycles 1-3, no retrigger in 4
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FR0, "multi_c1");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_FR1, "multi_c2_br");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FR1, "multi_c3");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_NORM, "multi_c4");
        idle(E_NORM, "multi_after");

        // mem wait: 5 pending cycles, then ack
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FR0, "mem_w1");
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FR2, "mem_wn");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_ACK, "mem_ack");
        idle(E_NORM, "mem_after");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_NORM, "mem_req_ack");
        idle(E_NORM, "mem_req_ack_after");

        // mem pending during EX_BUSY, resolved by ack
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FR0, "ovl_c1");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FR1, "ovl_c2");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FR1, "ovl_c3");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FR2, "ovl_memwait");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, E_ACK, "ovl_ack");
        idle(E_NORM, "ovl_after");

        // overlap then reset mid-MEM_WAIT
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FR0, "rst_ovl_c1");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FR1, "rst_ovl_c2");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FR1, "rst_ovl_c3");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FR2, "rst_ovl_mw");
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_RST, "rst_mid_mw");
        idle(E_NORM, "rst_no_residual");
        idle(E_NORM, "rst_no_residual2");

        // reset mid-EX_BUSY
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FR0, "rstx_c1");
        cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, E_FR1, "rstx_c2");
        cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_RST, "rst_mid_ex");
        idle(E_NORM, "rstx_after");

        // random run: invariants checked by the monitor every cycle
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            ex_memread_i      = $urandom_range(0, 1);
            ex_rd_i           = 5'($urandom_range(0, 3));
            id_rs1_i          = 5'($urandom_range(0, 3));
            id_rs2_i          = 5'($urandom_range(0, 3));
            id_branch_taken_i = $urandom_range(0, 1);
            ex_multi_i        = ($urandom_range(0, 7) == 0);
            mem_req_i         = ($urandom_range(0, 3) == 0);
            mem_ack_i         = $urandom_range(0, 1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
